video_timing_out: RTL and testbench

Generates 1024x768 @ 60 Hz (65 MHz pixel clock) raster timing and drives the VGA pins. It is the source of `hcount`/`vcount` for the graphics compositor and the sink of its 12-bit `pixel` result. Sync and blank are delayed through a matched pipeline so they line up with the compositor's fixed latency. It also emits a once-per-frame pulse for game-state latching.

---
 rtl/video_pkg.sv | 28 ++
 rtl/video_timing_out_sync_delay.sv | 29 ++
 rtl/video_timing_out.sv | 106 ++++++++++
 tb/tb_video_timing_out.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// Timing constants and the control-word type for the 1024x768 @ 60 Hz raster.
package video_pkg;

    localparam int H_ACTIVE = 1024;
    localparam int H_FP     = 24;
    localparam int H_SYNC   = 136;
    localparam int H_BP     = 160;
    localparam int V_ACTIVE = 768;
    localparam int V_FP     = 3;
    localparam int V_SYNC   = 6;
    localparam int V_BP     = 29;

    localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int H_SYNC_START = H_ACTIVE + H_FP;
    localparam int V_SYNC_START = V_ACTIVE + V_FP;

    // Sync/blank word carried down the delay line alongside the compositor
    typedef struct packed {
        logic hs;
        logic vs;
        logic blank;
    } ctrl_t;

    // Inactive syncs, blanked: what the pins show while nothing valid is in flight
    localparam ctrl_t CTRL_IDLE = '{hs: 1'b1, vs: 1'b1, blank: 1'b1};

endpackage

// File: rtl/video_timing_out_sync_delay.sv
// Fixed-depth shift register; every stage resets to RST_VAL so a reset flushes it.
module sync_delay #(
    parameter int                 WIDTH   = 3,
    parameter int                 DEPTH   = 9,
    parameter logic [WIDTH-1:0]   RST_VAL = '1
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [DEPTH-1:0][WIDTH-1:0] stage_pipe;

    // Shift one stage per cycle; stage 0 takes the fresh decode
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            stage_pipe <= {DEPTH{RST_VAL}};
        end else begin
            stage_pipe[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                stage_pipe[i] <= stage_pipe[i-1];
            end
        end
    end

    assign dout = stage_pipe[DEPTH-1];

endmodule

// File: rtl/video_timing_out.sv
// Raster counters, sync/blank decode, latency-matched VGA output stage and frame pulse.
module video_timing_out #(
    parameter int H_ACTIVE   = video_pkg::H_ACTIVE,
    parameter int H_FP       = video_pkg::H_FP,
    parameter int H_SYNC     = video_pkg::H_SYNC,
    parameter int H_BP       = video_pkg::H_BP,
    parameter int V_ACTIVE   = video_pkg::V_ACTIVE,
    parameter int V_FP       = video_pkg::V_FP,
    parameter int V_SYNC     = video_pkg::V_SYNC,
    parameter int V_BP       = video_pkg::V_BP,
    parameter int PIPE_DEPTH = 9
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic [11:0] pixel_in,
    output logic [10:0] hcount_out,
    output logic [9:0]  vcount_out,
    output logic        new_frame_out,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs
);

    import video_pkg::*;

    // Boundaries pre-sized to the counter widths so compares stay unsigned and exact
    localparam logic [10:0] H_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0]  V_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [10:0] HS_FIRST = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_LAST  = 11'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0]  VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0]  VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [9:0]  V_VIS    = 10'(V_ACTIVE);

    ctrl_t ctrl_raw;
    ctrl_t ctrl_dly;
    logic  at_last;

    assign at_last = (hcount_out == H_LAST) && (vcount_out == V_LAST);

    // Horizontal counter every cycle; vertical steps on horizontal wrap
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            hcount_out <= '0;
            vcount_out <= '0;
        end else if (hcount_out == H_LAST) begin
            hcount_out <= '0;
            vcount_out <= (vcount_out == V_LAST) ? '0 : vcount_out + 10'd1;
        end else begin
            hcount_out <= hcount_out + 11'd1;
        end
    end

    // Raw sync/blank for the counts presented this cycle
    always_comb begin
        ctrl_raw       = CTRL_IDLE;
        ctrl_raw.hs    = !((hcount_out >= HS_FIRST) && (hcount_out <= HS_LAST));
        ctrl_raw.vs    = !((vcount_out >= VS_FIRST) && (vcount_out <= VS_LAST));
        ctrl_raw.blank = (hcount_out >= H_VIS) || (vcount_out >= V_VIS);
    end

    // Match the compositor latency so control lines up with pixel_in
    sync_delay #(
        .WIDTH   ($bits(ctrl_t)),
        .DEPTH   (PIPE_DEPTH),
        .RST_VAL (CTRL_IDLE)
    ) u_sync_delay (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .din      (ctrl_raw),
        .dout     (ctrl_dly)
    );

    // Frame pulse lands in the cycle the counters show (0,0) after a real wrap
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) new_frame_out <= 1'b0;
        else           new_frame_out <= at_last;
    end

    // Registered pins: colour gated by delayed blank, syncs passed through
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vga_r  <= '0;
            vga_g  <= '0;
            vga_b  <= '0;
            vga_hs <= 1'b1;
            vga_vs <= 1'b1;
        end else begin
            if (ctrl_dly.blank) begin
                vga_r <= '0;
                vga_g <= '0;
                vga_b <= '0;
            end else begin
                vga_r <= pixel_in[11:8];
                vga_g <= pixel_in[7:4];
                vga_b <= pixel_in[3:0];
            end
            vga_hs <= ctrl_dly.hs;
            vga_vs <= ctrl_dly.vs;
        end
    end

endmodule

// File: tb/tb_video_timing_out.sv
// Directed checks: full-size timing for counting/hsync/blanking, a shrunken raster for frame/vsync/reset.
module tb_video_timing_out;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rst_s_n = 1'b0;
    logic [11:0] pixel = 12'hA5C;

    logic [10:0] hc, hc_s;
    logic [9:0]  vc, vc_s;
    logic        nf, nf_s;
    logic [3:0]  r, g, b, r_s, g_s, b_s;
    logic        hs, vs, hs_s, vs_s;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    video_timing_out u_dut (
        .clk_in(clk), .rst_n_in(rst_n), .pixel_in(pixel),
        .hcount_out(hc), .vcount_out(vc), .new_frame_out(nf),
        .vga_r(r), .vga_g(g), .vga_b(b), .vga_hs(hs), .vga_vs(vs)
    );

    // 24 x 12 raster: sync h 18..21, v 9..10, frame = 288 cycles
    video_timing_out #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(4), .H_BP(2),
        .V_ACTIVE(8),  .V_FP(1), .V_SYNC(2), .V_BP(1),
        .PIPE_DEPTH(9)
    ) u_small (
        .clk_in(clk), .rst_n_in(rst_s_n), .pixel_in(pixel),
        .hcount_out(hc_s), .vcount_out(vc_s), .new_frame_out(nf_s),
        .vga_r(r_s), .vga_g(g_s), .vga_b(b_s), .vga_hs(hs_s), .vga_vs(vs_s)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        int hs_low, vis, first_fall, nf_cnt, vs_low, first_pulse, pulses;
        logic prev;
        int hh, vv;
        logic [11:0] col_exp;
        logic hs_exp;

        // Reset hold
        repeat (20) @(negedge clk);
        chk("rst_rgb", {r, g, b}, 12'h000);
        chk("rst_hs", hs, 1'b1);
        chk("rst_vs", vs, 1'b1);
        chk("rst_nf", nf, 1'b0);
        chk("rst_cnt", {hc, vc}, 21'd0);
        rst_n = 1'b1;
        rst_s_n = 1'b1;

        // Full-size raster: first six lines plus the line-5 wrap
        hs_low = 0; vis = 0; first_fall = 0; nf_cnt = 0; prev = 1'b1;
        for (int n = 1; n <= 8070; n++) begin
            @(negedge clk);
            if (n <= 1353) begin
                if (!hs) hs_low++;
                if ({r, g, b} == 12'hA5C) vis++;
            end
            if (!hs && prev && first_fall == 0) first_fall = n;
            prev = hs;
            if (nf) nf_cnt++;
            if (n inside {1, 2, 3, 9, 10, 11, 1033, 1034, 1057, 1058, 1193, 1194,
                          1353, 1354, 8063, 8064}) begin
                hh = (n - 10) % 1344;
                vv = (n - 10) / 1344;
                col_exp = (n >= 10 && hh < 1024 && vv < 768) ? 12'hA5C : 12'h000;
                hs_exp  = !(n >= 10 && hh >= 1048 && hh <= 1183);
                chk($sformatf("hc@%0d", n), hc, n % 1344);
                chk($sformatf("vc@%0d", n), vc, n / 1344);
                chk($sformatf("rgb@%0d", n), {r, g, b}, col_exp);
                chk($sformatf("hs@%0d", n), hs, hs_exp);
                chk($sformatf("vs@%0d", n), vs, 1'b1);
            end
        end
        chk("hs_first_fall", first_fall, 1058);
        chk("hs_low_width", hs_low, 136);
        chk("visible_pixels_line0", vis, 1024);
        chk("no_early_pulse", nf_cnt, 0);

        // Shrunken raster has been running since the same release edge
        // (8070 cycles = 28 frames + 6 cycles); restart it cleanly
        rst_s_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_s_n = 1'b1;
        first_pulse = 0; pulses = 0; vs_low = 0; first_fall = 0; prev = 1'b1;
        for (int n = 1; n <= 604; n++) begin
            @(negedge clk);
            if (nf_s) begin
                pulses++;
                if (first_pulse == 0) begin
                    first_pulse = n;
                    chk("pulse_cnt00", {hc_s, vc_s}, 21'd0);
                end
            end
            if (n <= 298 && !vs_s) vs_low++;
            if (!vs_s && prev && first_fall == 0) first_fall = n;
            prev = vs_s;
        end
        chk("first_pulse_at_frame", first_pulse, 288);
        chk("pulses_two_frames", pulses, 2);
        chk("vs_first_fall", first_fall, 226);
        chk("vs_low_width", vs_low, 48);
        chk("mid_pre_hs_low", hs_s, 1'b0);
        chk("mid_pre_cnt", {hc_s, vc_s}, {11'd4, 10'd1});

        // Mid-frame reset while hsync is low on the pins
        rst_s_n = 1'b0;
        #1;
        chk("mid_cnt", {hc_s, vc_s}, 21'd0);
        chk("mid_hs", hs_s, 1'b1);
        chk("mid_vs", vs_s, 1'b1);
        chk("mid_rgb", {r_s, g_s, b_s}, 12'h000);
        chk("mid_nf", nf_s, 1'b0);
        repeat (3) @(negedge clk);
        rst_s_n = 1'b1;
        hs_low = 0; first_pulse = 0;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (n <= 27 && !hs_s) hs_low++;
            if (nf_s && first_pulse == 0) first_pulse = n;
            if (n == 5) chk("resume_cnt", {hc_s, vc_s}, {11'd5, 10'd0});
            if (n == 28) chk("resume_hs_low", hs_s, 1'b0);
        end
        chk("resume_no_glitch", hs_low, 0);
        chk("resume_first_pulse", first_pulse, 288);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
